// File: rtl/aw_w_b_channel.sv
// rtl/aw_w_b_channel.sv - single-outstanding AXI write channel (AW/W/B) behind an sram-like port; optional AXI_WR_RESP_CHK_EN drives sticky wr_err
// Ports: clk, reset (sync, active-high); sram write request in, wr_addr_ok/wr_data_ok out;
//        AXI AW/W masters, B slave; wr_busy/wr_pend_addr for read-after-write blocking; wr_err.
module aw_w_b_channel (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_wr_addr_ok,
    output logic        data_sram_wr_data_ok,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic        wr_busy,
    output logic [31:0] wr_pend_addr,
    output logic        wr_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEND   = 2'd1;
    localparam logic [1:0] S_WAIT_B = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_hs, w_hs;

    // bid is never checked; bresp only matters with the error flag built in
    logic unused_b;
    assign unused_b = ^{bid, bresp};

    assign aw_hs = awvalid_q && awready;
    assign w_hs  = wvalid_q && wready;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE: begin
                // reads (req && !wr) never start anything here
                if (data_sram_req && data_sram_wr) begin
                    addr_d    = data_sram_addr;
                    size_d    = {1'b0, data_sram_size};
                    wstrb_d   = data_sram_wstrb;
                    wdata_d   = data_sram_wdata;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                // leave once neither channel still has an un-handshaken beat
                if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (bvalid) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            addr_q    <= 32'd0;
            size_q    <= 3'd0;
            wstrb_q   <= 4'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef AXI_WR_RESP_CHK_EN
    logic wr_err_q, wr_err_d;

    // sticky: any non-OKAY response is remembered until reset
    always_comb begin
        wr_err_d = wr_err_q;
        if (state_q == S_WAIT_B && bvalid && bresp != 2'b00) begin
            wr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

    assign data_sram_wr_addr_ok = (state_q == S_IDLE);
    assign data_sram_wr_data_ok = (state_q == S_DONE);
    assign bready               = (state_q == S_WAIT_B);
    assign wr_busy              = (state_q != S_IDLE);
    assign wr_pend_addr         = addr_q;

    assign awid    = 4'd1;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = size_q;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q;

    assign wid    = 4'd1;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign wlast  = 1'b1;
    assign wvalid = wvalid_q;

endmodule
